// File: rtl/cotm32_fetch_unit_pkg.sv
// Shared COTM32 pipeline types used by the fetch stage: IF/ID record, fetch FSM states, NOP encoding.
package cotm32_pipeline_pkg;

    localparam int XLEN       = 32;
    localparam int INST_WIDTH = 32;

    localparam logic [INST_WIDTH-1:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0]       pc;
        logic [XLEN-1:0]       pc_4;
        logic [INST_WIDTH-1:0] inst;
    } ifid_data_t;

    typedef enum logic [1:0] {
        FS_REQ  = 2'd0,
        FS_WAIT = 2'd1,
        FS_HOLD = 2'd2
    } fetch_state_t;

    // PC arithmetic wraps modulo 2^XLEN by construction of the vector width.
    function automatic ifid_data_t make_ifid(input logic [XLEN-1:0] pc,
                                             input logic [INST_WIDTH-1:0] inst);
        ifid_data_t r;
        r.pc   = pc;
        r.pc_4 = pc + XLEN'(4);
        r.inst = inst;
        return r;
    endfunction

endpackage

// File: rtl/cotm32_fetch_unit_if.sv
// Instruction-memory and IF/ID bus bundle for the fetch unit.
// ifid_misaligned exists only when COTM32_FETCH_ALIGN_CHECK_EN is defined.
interface cotm32_fetch_unit_if;
    import cotm32_pipeline_pkg::*;

    logic                  imem_req;
    logic [XLEN-1:0]       imem_addr;
    logic                  imem_gnt;
    logic                  imem_rvalid;
    logic [INST_WIDTH-1:0] imem_rdata;
    logic                  ifid_valid;
    logic                  ifid_ready;
    ifid_data_t            ifid_data;
`ifdef COTM32_FETCH_ALIGN_CHECK_EN
    logic                  ifid_misaligned;
`endif

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata,
        input  ifid_ready,
        output ifid_valid,
`ifdef COTM32_FETCH_ALIGN_CHECK_EN
        output ifid_misaligned,
`endif
        output ifid_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata,
        output ifid_ready,
        input  ifid_valid,
`ifdef COTM32_FETCH_ALIGN_CHECK_EN
        input  ifid_misaligned,
`endif
        input  ifid_data
    );

endinterface

// File: rtl/cotm32_fetch_unit_skid.sv
// One-entry valid/ready register slice with flush; payload type is a parameter.
module cotm32_skid_buf #(
    parameter type T = logic
) (
    input  logic clk,
    input  logic rst,
    input  logic flush_i,
    input  logic in_valid_i,
    output logic in_ready_o,
    input  T     in_data_i,
    output logic out_valid_o,
    input  logic out_ready_i,
    output T     out_data_o
);

    logic valid_q;
    T     data_q;

    // Data only moves on a load, so the output is stable while stalled.
    assign in_ready_o  = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (in_valid_i && in_ready_o) begin
            valid_q <= 1'b1;
            data_q  <= in_data_i;
        end else if (out_ready_i) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/cotm32_fetch_unit.sv
// COTM32 instruction fetch stage: PC, single-outstanding imem requests, IF/ID skid slot, redirects.
// Optional COTM32_FETCH_ALIGN_CHECK_EN reports misaligned redirect targets instead of fetching them.
module cotm32_fetch_unit
    import cotm32_pipeline_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    cotm32_fetch_unit_if.master bus
);

`ifdef COTM32_FETCH_ALIGN_CHECK_EN
    typedef struct packed {
        logic       misaligned;
        ifid_data_t rec;
    } slot_t;
`else
    typedef struct packed {
        ifid_data_t rec;
    } slot_t;
`endif

    fetch_state_t    state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] req_pc_q;
    logic            drop_q;
    logic            hold_valid_q;
    logic            halt_q;
    slot_t           hold_q;

    slot_t           rsp_slot;
    slot_t           mis_slot;
    slot_t           slot_in;
    slot_t           slot_out;
    logic            slot_push;
    logic            slot_in_ready;
    logic            slot_valid;
    logic            fire;
    logic            rsp_room;
    logic            hold_push;
    logic            redir_mis;
    logic [XLEN-1:0] redir_pc;

`ifdef COTM32_FETCH_ALIGN_CHECK_EN
    assign redir_pc  = redirect_pc;
    assign redir_mis = |redirect_pc[1:0];
`else
    assign redir_pc  = redirect_pc & ~XLEN'(3);
    assign redir_mis = 1'b0;
`endif

    always_comb begin
        rsp_slot     = '0;
        rsp_slot.rec = make_ifid(req_pc_q, bus.imem_rdata);
        mis_slot     = '0;
        mis_slot.rec = make_ifid(redir_pc, NOP_INST);
`ifdef COTM32_FETCH_ALIGN_CHECK_EN
        mis_slot.misaligned = 1'b1;
`endif
    end

    // Only request when the slot is guaranteed room for the response.
    assign bus.imem_req  = !rst && (state_q == FS_REQ) && !drop_q && slot_in_ready;
    assign bus.imem_addr = pc_q;
    assign fire          = bus.imem_req && bus.imem_gnt;

    assign rsp_room  = (state_q == FS_WAIT) && bus.imem_rvalid && !redirect_valid && slot_in_ready;
    assign hold_push = (state_q == FS_HOLD) && hold_valid_q && !redirect_valid && slot_in_ready;
    assign slot_push = rsp_room || hold_push;
    assign slot_in   = hold_push ? hold_q : rsp_slot;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FS_REQ;
            pc_q         <= RESET_PC;
            req_pc_q     <= RESET_PC;
            drop_q       <= 1'b0;
            hold_valid_q <= 1'b0;
            halt_q       <= 1'b0;
            hold_q       <= '0;
        end else begin
            if (drop_q && bus.imem_rvalid) begin
                drop_q <= 1'b0;
            end
            if (redirect_valid) begin
                pc_q         <= redir_pc;
                state_q      <= FS_REQ;
                hold_valid_q <= 1'b0;
                halt_q       <= 1'b0;
                // A response still owed for an old-PC grant must be swallowed.
                drop_q       <= ((drop_q || (state_q == FS_WAIT)) && !bus.imem_rvalid) || fire;
                if (redir_mis) begin
                    state_q      <= FS_HOLD;
                    halt_q       <= 1'b1;
                    hold_valid_q <= 1'b1;
                    hold_q       <= mis_slot;
                end
            end else begin
                case (state_q)
                    FS_REQ: begin
                        if (fire) begin
                            state_q  <= FS_WAIT;
                            req_pc_q <= pc_q;
                        end
                    end
                    FS_WAIT: begin
                        if (bus.imem_rvalid) begin
                            pc_q <= req_pc_q + XLEN'(4);
                            if (rsp_room) begin
                                state_q <= FS_REQ;
                            end else begin
                                hold_q       <= rsp_slot;
                                hold_valid_q <= 1'b1;
                                state_q      <= FS_HOLD;
                            end
                        end
                    end
                    FS_HOLD: begin
                        if (hold_push) begin
                            hold_valid_q <= 1'b0;
                            if (!halt_q) begin
                                state_q <= FS_REQ;
                            end
                        end else if (!hold_valid_q && !halt_q) begin
                            state_q <= FS_REQ;
                        end
                    end
                    default: state_q <= FS_REQ;
                endcase
            end
        end
    end

    cotm32_skid_buf #(.T(slot_t)) u_ifid_slot (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (redirect_valid),
        .in_valid_i  (slot_push),
        .in_ready_o  (slot_in_ready),
        .in_data_i   (slot_in),
        .out_valid_o (slot_valid),
        .out_ready_i (bus.ifid_ready),
        .out_data_o  (slot_out)
    );

    assign bus.ifid_valid = slot_valid;
    assign bus.ifid_data  = slot_out.rec;
`ifdef COTM32_FETCH_ALIGN_CHECK_EN
    assign bus.ifid_misaligned = slot_valid && slot_out.misaligned;
`endif

endmodule

// File: tb/tb_cotm32_fetch_unit.sv
// Scoreboard bench for cotm32_fetch_unit: memory model, IF/ID monitor, directed redirect scenarios.
module tb_cotm32_fetch_unit;
    import cotm32_pipeline_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    cotm32_fetch_unit_if bus();

    cotm32_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] inst;
        logic        mis;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    exp_t        exp_q[$];
    logic [31:0] addr_q[$];
    int          xfer_t[$];
    int          xfer_cnt = 0;
    int          grants_left = 0;
    int          lat = 1;
    int          cnt = 0;
    logic        pend = 1'b0;
    logic [31:0] paddr = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check_eq(input string name, input logic [95:0] got, input logic [95:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic expect_run(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            exp_t        e;
            logic [31:0] a;
            a      = start + 32'(4 * i);
            e.pc   = a;
            e.pc4  = a + 32'd4;
            e.inst = inst_of(a);
            e.mis  = 1'b0;
            addr_q.push_back(a);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0 && addr_q.size() == 0 && !pend) break;
            tick();
        end
        check_eq({name, "_drain"}, 96'(exp_q.size() + addr_q.size()), 96'd0);
        repeat (5) tick();
    endtask

    task automatic do_redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        tick();
        redirect_valid = 1'b0;
    endtask

    // Instruction memory: grants while budget remains, answers after lat cycles.
    initial begin
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst && bus.imem_req && bus.imem_gnt) begin
                check_eq("single_outstanding", 96'(pend), 96'd0);
                if (addr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req: got addr %h expected no request", bus.imem_addr);
                end else begin
                    check_eq("req_addr", 96'(bus.imem_addr), 96'(addr_q.pop_front()));
                end
                pend  = 1'b1;
                paddr = bus.imem_addr;
                cnt   = lat;
                if (grants_left > 0) grants_left--;
            end
            @(posedge clk);
            #1;
            bus.imem_rvalid = 1'b0;
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    bus.imem_rvalid = 1'b1;
                    bus.imem_rdata  = inst_of(paddr);
                    pend            = 1'b0;
                end
            end
            bus.imem_gnt = (grants_left > 0);
        end
    end

    // IF/ID monitor: scoreboard pop on transfer, stall stability and no-request checks.
    initial begin
        logic       held_v;
        ifid_data_t held_d;
        held_v = 1'b0;
        held_d = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.ifid_valid && held_v) begin
                    check_eq("hold_stable", bus.ifid_data, held_d);
                end
                if (bus.ifid_valid && !bus.ifid_ready) begin
                    check_eq("no_req_when_full", 96'(bus.imem_req), 96'd0);
                    held_v = 1'b1;
                    held_d = bus.ifid_data;
                end else begin
                    held_v = 1'b0;
                end
                if (bus.ifid_valid && bus.ifid_ready) begin
                    logic mis_got;
                    xfer_t.push_back(cyc);
                    xfer_cnt++;
`ifdef COTM32_FETCH_ALIGN_CHECK_EN
                    mis_got = bus.ifid_misaligned;
`else
                    mis_got = 1'b0;
`endif
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_rec: got pc=%h inst=%h expected none",
                                 bus.ifid_data.pc, bus.ifid_data.inst);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        if (bus.ifid_data.pc !== e.pc || bus.ifid_data.pc_4 !== e.pc4 ||
                            bus.ifid_data.inst !== e.inst || mis_got !== e.mis) begin
                            errors++;
                            $display("FAIL rec: got pc=%h pc_4=%h inst=%h mis=%b expected pc=%h pc_4=%h inst=%h mis=%b",
                                     bus.ifid_data.pc, bus.ifid_data.pc_4, bus.ifid_data.inst, mis_got,
                                     e.pc, e.pc4, e.inst, e.mis);
                        end else begin
                            $display("rec pc=%h pc_4=%h inst=%h mis=%b ok", e.pc, e.pc4, e.inst, e.mis);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int base;
        bus.ifid_ready = 1'b1;

        // Sequential stream from reset, zero-wait memory.
        expect_run(32'h0, 8);
        grants_left = 8;
        repeat (3) tick();
        @(negedge clk);
        check_eq("rst_imem_req", 96'(bus.imem_req), 96'd0);
        check_eq("rst_ifid_valid", 96'(bus.ifid_valid), 96'd0);
        check_eq("rst_ifid_data", bus.ifid_data, 96'd0);
        check_eq("rst_imem_addr", 96'(bus.imem_addr), 96'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        t0 = cyc;
        check_eq("first_req", 96'(bus.imem_req), 96'd1);
        wait_drain("seq");
        if (xfer_t.size() >= 8) begin
            check_eq("first_latency", 96'(xfer_t[0] - t0), 96'd2);
            check_eq("throughput", 96'(xfer_t[7] - xfer_t[0]), 96'd14);
        end else begin
            check_eq("seq_count", 96'(xfer_t.size()), 96'd8);
        end

        // Decode back-pressure for 5 cycles mid-stream.
        base = xfer_cnt;
        expect_run(32'h20, 8);
        grants_left = 8;
        for (int i = 0; i < 100; i++) begin
            if (xfer_cnt >= base + 2) break;
            tick();
        end
        check_eq("bp_started", 96'(xfer_cnt >= base + 2), 96'd1);
        bus.ifid_ready = 1'b0;
        repeat (5) tick();
        bus.ifid_ready = 1'b1;
        wait_drain("backpressure");

        // Redirect while a 3-cycle response is outstanding.
        lat = 3;
        addr_q.push_back(32'h40);
        expect_run(32'h100, 2);
        grants_left = 3;
        for (int i = 0; i < 50; i++) begin
            if (pend) break;
            tick();
        end
        check_eq("outstanding_seen", 96'(pend), 96'd1);
        do_redirect(32'h100);
        wait_drain("redir_wait");
        lat = 1;

        // Redirect in the same cycle as the grant.
        addr_q.push_back(32'h108);
        expect_run(32'h200, 2);
        grants_left = 3;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        @(negedge clk);
        check_eq("grant_with_redirect", 96'(bus.imem_req && bus.imem_gnt), 96'd1);
        tick();
        redirect_valid = 1'b0;
        wait_drain("redir_grant");

        // PC wrap at the top of the address space.
        expect_run(32'hFFFF_FFF8, 3);
        grants_left = 3;
        do_redirect(32'hFFFF_FFF8);
        wait_drain("wrap");

        // Misaligned redirect target.
        grants_left = 2;
`ifdef COTM32_FETCH_ALIGN_CHECK_EN
        begin
            exp_t e;
            e.pc   = 32'h102;
            e.pc4  = 32'h106;
            e.inst = 32'h0000_0013;
            e.mis  = 1'b1;
            exp_q.push_back(e);
        end
        do_redirect(32'h102);
        wait_drain("misaligned");
        repeat (5) tick();
        @(negedge clk);
        check_eq("misaligned_idle", 96'(bus.imem_req), 96'd0);
`else
        expect_run(32'h100, 2);
        do_redirect(32'h102);
        wait_drain("misaligned");
`endif

        // Aligned redirect resumes normal fetch.
        expect_run(32'h300, 2);
        grants_left = 2;
        do_redirect(32'h300);
        wait_drain("resume");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
